uart_tx_frame_gen: RTL
======================

// Module: uart_tx_frame_gen
// PURPOSE
//  Parametrised UART transmit framer: the sequencer and output select of the UART TX path in one block.
//  Latches a parallel word and serialises start, DATA_W data bits (LSB first), optional parity and 1 or 2 stop bits.
//  One bit per CLK cycle: CLK is the TX baud/oversample-divided clock from the clock divider.
//  Sits between the SYS_CTRL/FIFO read side and the TX pin.
// PARAMETERS
//  DATA_W   8  data bits per frame, 5..9
//  CNT_W    4  bit-counter width, must satisfy 2**CNT_W > DATA_W
// PORTS
//  CLK         in   1       TX clock; all logic on rising edge
//  RST         in   1       synchronous, active-high reset
//  P_DATA      in   DATA_W  parallel word to send
//  DATA_VALID  in   1       P_DATA valid; word accepted when DATA_VALID & ~BUSY
//  PAR_EN      in   1       1 = parity bit inserted after data
//  PAR_TYP     in   1       0 = even, 1 = odd
//  STOP2       in   1       1 = two stop bits, 0 = one stop bit
//  TX_OUT      out  1       serial line, idle high
//  BUSY        out  1       frame in progress; new words refused
//  FRAME_DONE  out  1       one-cycle pulse in the last stop-bit cycle
// BEHAVIOUR
//  Reset: TX_OUT=1, BUSY=0, FRAME_DONE=0, state IDLE, counter 0, data/config regs 0. Reset mid-frame aborts the frame:
//   the next cycle drives TX_OUT=1 and BUSY=0. No partial frame resumes.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//  IDLE: TX_OUT=1, BUSY=0. On DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP, STOP2 and parity, then go to START.
//   Config inputs are sampled only at acceptance. Later changes do not affect the frame in flight.
//  Parity: even = ^data, odd = ~^data, computed on the latched word.
//  START: TX_OUT=0 for 1 cycle. The start bit appears the cycle after acceptance (latency 1).
//  DATA: TX_OUT=data[cnt], cnt 0..DATA_W-1. Stay exactly DATA_W cycles.
//   At cnt==DATA_W-1, clear cnt and go to PARITY if PAR_EN, else to STOP1.
//  PARITY: TX_OUT=parity for 1 cycle, then STOP1.
//  STOP1/STOP2: TX_OUT=1. STOP1 goes to STOP2 if the latched STOP2=1, else to IDLE. STOP2 always goes to IDLE.
//  FRAME_DONE=1 only in the final stop cycle.
//  BUSY=1 in every state except IDLE. It is registered and rises the cycle after acceptance.
//  Frame length = 1+DATA_W+PAR_EN+1+STOP2 cycles. Back-to-back frames have a minimum of 1 IDLE (high) cycle between them.
//  DATA_VALID while BUSY=1 is ignored: no buffering, no error. The source must hold DATA_VALID until accepted.
//  TX_OUT is registered (glitch-free line). Any unused state encoding recovers to IDLE with TX_OUT=1.
// CONFIGURATION
//  UART_TX_BREAK_EN defined: adds input BREAK_REQ (1 bit).
//   If BREAK_REQ=1 in IDLE, enter BREAK: TX_OUT=0 and BUSY=1 while BREAK_REQ=1, DATA_VALID ignored.
//   On BREAK_REQ=0, go to STOP1 (one stop bit forced), then IDLE.
//   BREAK_REQ takes priority over DATA_VALID in the same IDLE cycle. BREAK_REQ during a frame is ignored until IDLE.
//  Macro undefined: no BREAK_REQ port, no BREAK state, behaviour exactly as above.
// STRUCTURE
//  Package uart_tx_pkg:
//   state encoding localparams (IDLE=3'b000, START=3'b001, DATA=3'b011, PARITY=3'b010, STOP1=3'b110, STOP2=3'b111, BREAK=3'b100);
//   PAR_EVEN/PAR_ODD constants.
//  Sub-module uart_tx_parity_calc (DATA_W param; data, typ -> bit), shared with the RX parity checker.
//  The FSM, counter, shift select and output register stay in this module.
// TESTING
//  1. DATA_W=8, P_DATA=8'hA5, PAR_EN=0, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 over 10 cycles; FRAME_DONE in cycle 10; BUSY low after.
//  2. P_DATA=8'h07, PAR_EN=1: PAR_TYP=0 -> parity bit 1; PAR_TYP=1 -> parity 0; frame 11 cycles.
//  3. STOP2=1, PAR_EN=1 -> 12-cycle frame with 2 high stop bits; FRAME_DONE only in the 2nd stop cycle.
//  4. DATA_VALID held high with 8'h55 then 8'hAA -> two frames separated by exactly 1 idle high cycle;
//     a word pulsed mid-frame is not sent.
//  5. RST=1 in DATA cycle 4 -> next cycle TX_OUT=1, BUSY=0. A new word after reset sends a full, correct frame.
//  6. UART_TX_BREAK_EN: BREAK_REQ high for 20 cycles together with DATA_VALID -> TX_OUT low for 20 cycles,
//     1 stop cycle, then the pending word is sent.
//     Without the macro, the same bench minus BREAK_REQ passes 1-5.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX framer: state encodings and parity-type constants.
package uart_tx_pkg;

   localparam logic [2:0] ENC_IDLE   = 3'b000;
   localparam logic [2:0] ENC_START  = 3'b001;
   localparam logic [2:0] ENC_DATA   = 3'b011;
   localparam logic [2:0] ENC_PARITY = 3'b010;
   localparam logic [2:0] ENC_STOP1  = 3'b110;
   localparam logic [2:0] ENC_STOP2  = 3'b111;
   localparam logic [2:0] ENC_BREAK  = 3'b100;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = ENC_IDLE,
      ST_START  = ENC_START,
      ST_DATA   = ENC_DATA,
      ST_PARITY = ENC_PARITY,
      ST_STOP1  = ENC_STOP1,
      ST_STOP2  = ENC_STOP2,
      ST_BREAK  = ENC_BREAK
   } tx_state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator for a DATA_W-bit word; shared between the TX framer and the RX parity checker.
module uart_tx_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              typ,
   output logic              par
);

   always_comb begin
      par = ^data;
      case (typ)
         PAR_EVEN: par = ^data;
         PAR_ODD:  par = ~^data;
         default:  par = ^data;
      endcase
   end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART TX framer: start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits, one bit per CLK.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN (adds BREAK_REQ).
module uart_tx_frame_gen
   import uart_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] P_DATA,
   input  logic              DATA_VALID,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   input  logic              STOP2,
`ifdef UART_TX_BREAK_EN
   input  logic              BREAK_REQ,
`endif
   output logic              TX_OUT,
   output logic              BUSY,
   output logic              FRAME_DONE
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   tx_state_e         state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              par_en_reg, par_en_next;
   logic              parity_reg, parity_next;
   logic              stop2_reg, stop2_next;
   logic              tx_reg, tx_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              par_in;
   logic              data_bit;

   uart_tx_parity_calc #(.DATA_W(DATA_W)) u_parity (
      .data (P_DATA),
      .typ  (PAR_TYP),
      .par  (par_in)
   );

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      data_next   = data_reg;
      par_en_next = par_en_reg;
      parity_next = parity_reg;
      stop2_next  = stop2_reg;
      case (state_reg)
         ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
            // A break ends with exactly one stop bit, so the stop-count flag is cleared on entry.
            if (BREAK_REQ) begin
               state_next = ST_BREAK;
               stop2_next = 1'b0;
            end else
`endif
            if (DATA_VALID) begin
               data_next   = P_DATA;
               par_en_next = PAR_EN;
               parity_next = par_in;
               stop2_next  = STOP2;
               state_next  = ST_START;
            end
         end
         ST_START: begin
            cnt_next   = '0;
            state_next = ST_DATA;
         end
         ST_DATA: begin
            if (cnt_reg == LAST_BIT) begin
               cnt_next   = '0;
               state_next = par_en_reg ? ST_PARITY : ST_STOP1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_PARITY: state_next = ST_STOP1;
         ST_STOP1:  state_next = stop2_reg ? ST_STOP2 : ST_IDLE;
         ST_STOP2:  state_next = ST_IDLE;
`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            if (!BREAK_REQ) state_next = ST_STOP1;
         end
`endif
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      data_bit = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (cnt_next == CNT_W'(i)) data_bit = data_next[i];
      end

      // Outputs are decoded from the next state so the registered line lines up with the state.
      tx_next = 1'b1;
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = data_bit;
         ST_PARITY: tx_next = parity_next;
         ST_BREAK:  tx_next = 1'b0;
         default:   tx_next = 1'b1;
      endcase
      busy_next = (state_next != ST_IDLE);
      done_next = (state_next == ST_STOP2) || ((state_next == ST_STOP1) && !stop2_next);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         data_reg   <= '0;
         par_en_reg <= 1'b0;
         parity_reg <= 1'b0;
         stop2_reg  <= 1'b0;
         tx_reg     <= 1'b1;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         data_reg   <= data_next;
         par_en_reg <= par_en_next;
         parity_reg <= parity_next;
         stop2_reg  <= stop2_next;
         tx_reg     <= tx_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign TX_OUT     = tx_reg;
   assign BUSY       = busy_reg;
   assign FRAME_DONE = done_reg;

endmodule
